// File: rtl/a23_rotate_pkg.sv
// Shared widths, direction encodings and requester ID type for the rotate arbiter.
package a23_rotate_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_AMT_W  = 5;

  localparam logic ROT_LEFT  = 1'b0;
  localparam logic ROT_RIGHT = 1'b1;

  typedef logic req_id_t;

  localparam req_id_t REQ_ID_0 = 1'b0;
  localparam req_id_t REQ_ID_1 = 1'b1;

endpackage

// File: rtl/a23_rotate_core.sv
// Purely combinational log-depth barrel rotator: stage i rotates by 2^i when amount bit i is set.
module a23_rotate_core
  import a23_rotate_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned AMT_W  = DEF_AMT_W
) (
  input  logic [DATA_W-1:0] operand_i,
  input  logic [AMT_W-1:0]  amount_i,
  input  logic              dir_i,
  output logic [DATA_W-1:0] result_o
);

  logic [DATA_W-1:0] acc;
  int unsigned       sh;

  // Cascade of conditional power-of-two rotations; left and right share the same staging.
  always_comb begin
    acc = operand_i;
    sh  = 0;
    for (int i = 0; i < int'(AMT_W); i++) begin
      sh = 32'(1) << i;
      if (amount_i[i]) begin
        if (dir_i == ROT_RIGHT) begin
          acc = (acc >> sh) | (acc << (DATA_W - sh));
        end else begin
          acc = (acc << sh) | (acc >> (DATA_W - sh));
        end
      end
    end
    result_o = acc;
  end

endmodule

// File: rtl/a23_rotate_arbiter.sv
// Two-requester round-robin front end sharing one barrel rotator, with a single registered response slot.
module a23_rotate_arbiter
  import a23_rotate_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned AMT_W  = DEF_AMT_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_data,
  input  logic [AMT_W-1:0]  i_req0_amount,
  input  logic              i_req0_dir,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_data,
  input  logic [AMT_W-1:0]  i_req1_amount,
  input  logic              i_req1_dir,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output req_id_t           o_rsp_id
);

  if (AMT_W != $clog2(DATA_W) || DATA_W != (32'(1) << AMT_W)) begin : g_param_check
    $error("a23_rotate_arbiter: DATA_W must be a power of two and AMT_W must equal log2(DATA_W)");
  end

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  req_id_t           rsp_id_q,    rsp_id_d;
  req_id_t           last_q,      last_d;

  logic              grant0, grant1;
  logic              can_accept;
  logic              xfer;
  req_id_t           sel_id;
  logic [DATA_W-1:0] sel_data;
  logic [AMT_W-1:0]  sel_amount;
  logic              sel_dir;
  logic [DATA_W-1:0] rot_result;

  // Round-robin grant: on contention the requester that did not win the last transfer goes next.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      if (last_q == REQ_ID_1) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      grant0 = i_req0_valid;
      grant1 = i_req1_valid;
    end
  end

  // Handshake: accept only when the result slot is empty or being drained; silent while in reset.
  always_comb begin
    can_accept   = ~rsp_valid_q | i_rsp_ready;
    o_req0_ready = grant0 & can_accept & i_rst_n;
    o_req1_ready = grant1 & can_accept & i_rst_n;
    xfer         = o_req0_ready | o_req1_ready;
  end

  // Steer the granted requester's operation into the shared rotator.
  always_comb begin
    sel_id     = grant1 ? REQ_ID_1 : REQ_ID_0;
    sel_data   = grant1 ? i_req1_data   : i_req0_data;
    sel_amount = grant1 ? i_req1_amount : i_req0_amount;
    sel_dir    = grant1 ? i_req1_dir    : i_req0_dir;
  end

  a23_rotate_core #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W)
  ) u_core (
    .operand_i (sel_data),
    .amount_i  (sel_amount),
    .dir_i     (sel_dir),
    .result_o  (rot_result)
  );

  // Result slot and last-grant pointer update; pointer moves only on an actual transfer.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    last_d      = last_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rot_result;
      rsp_id_d    = sel_id;
      last_d      = sel_id;
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers; reset points last grant at requester 1 so requester 0 wins first contention.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= REQ_ID_0;
      last_q      <= REQ_ID_1;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      last_q      <= last_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_a23_rotate_arbiter.sv
// Self-checking bench for a23_rotate_arbiter: directed scenarios plus a scoreboard of accepted requests.
module tb_a23_rotate_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        o_req0_ready, o_req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_amount, req1_amount;
  logic        req0_dir, req1_dir;
  logic        o_rsp_valid;
  logic        rsp_ready;
  logic [31:0] o_rsp_data;
  logic        o_rsp_id;

  int   vectors;
  int   miscompares;
  exp_t sb[$];

  a23_rotate_arbiter dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req0_valid  (req0_valid),
    .o_req0_ready  (o_req0_ready),
    .i_req0_data   (req0_data),
    .i_req0_amount (req0_amount),
    .i_req0_dir    (req0_dir),
    .i_req1_valid  (req1_valid),
    .o_req1_ready  (o_req1_ready),
    .i_req1_data   (req1_data),
    .i_req1_amount (req1_amount),
    .i_req1_dir    (req1_dir),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_data    (o_rsp_data),
    .o_rsp_id      (o_rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rotate, bit by bit from the index definition.
  function automatic logic [31:0] rot_ref(input logic [31:0] d, input logic [4:0] a, input logic dir);
    logic [31:0] r;
    int idx;
    for (int j = 0; j < 32; j++) begin
      idx  = dir ? (j + int'(a)) % 32 : (j + 32 - int'(a)) % 32;
      r[j] = d[idx];
    end
    return r;
  endfunction

  // Scoreboard monitor: pop/compare consumed results, then push newly accepted requests.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (o_req0_ready && o_req1_ready) begin
        vectors++;
        miscompares++;
        $display("FAIL dual_ready: both readies high at %0t", $time);
      end
      if (o_rsp_valid && rsp_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_extra: response id=%0d data=%h with nothing expected", o_rsp_id, o_rsp_data);
        end else begin
          e = sb.pop_front();
          if (o_rsp_data !== e.data || o_rsp_id !== e.id) begin
            miscompares++;
            $display("FAIL sb_rsp: got id=%0d data=%h, expected id=%0d data=%h", o_rsp_id, o_rsp_data, e.id, e.data);
          end
        end
      end
      if (req0_valid && o_req0_ready) sb.push_back('{1'b0, rot_ref(req0_data, req0_amount, req0_dir)});
      if (req1_valid && o_req1_ready) sb.push_back('{1'b1, rot_ref(req1_data, req1_amount, req1_dir)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 32'h1; req1_data = 32'h2;
    req0_amount = '0; req1_amount = '0;
    req0_dir = 1'b0; req1_dir = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_rsp_data !== 32'h0 || o_rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rsp: valid=%b data=%h id=%b, expected 0/0/0", o_rsp_valid, o_rsp_data, o_rsp_id);
    end
    vectors++;
    if (o_req0_ready !== 1'b0 || o_req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: ready0=%b ready1=%b, expected 0/0", o_req0_ready, o_req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_req0_only();
    step();
    req0_valid = 1'b1; req0_data = 32'h8000_0001; req0_amount = 5'd1; req0_dir = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL req0_ready: ready0=%b ready1=%b, expected 1/0", o_req0_ready, o_req1_ready);
    end
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h0000_0003 || o_rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL req0_rsp: valid=%b data=%h id=%b, expected 1/00000003/0", o_rsp_valid, o_rsp_data, o_rsp_id);
    end
  endtask

  task automatic test_req1_only();
    logic [4:0]  amt [2];
    logic [31:0] exp_d [2];
    amt[0] = 5'd4; exp_d[0] = 32'h1000_0000;
    amt[1] = 5'd0; exp_d[1] = 32'h0000_0001;
    for (int k = 0; k < 2; k++) begin
      step();
      req1_valid = 1'b1; req1_data = 32'h0000_0001; req1_amount = amt[k]; req1_dir = 1'b1;
      @(negedge clk);
      vectors++;
      if (o_req1_ready !== 1'b1 || o_req0_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL req1_ready[%0d]: ready0=%b ready1=%b, expected 0/1", k, o_req0_ready, o_req1_ready);
      end
      step();
      req1_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== exp_d[k] || o_rsp_id !== 1'b1) begin
        miscompares++;
        $display("FAIL req1_rsp[%0d]: valid=%b data=%h id=%b, expected 1/%h/1", k, o_rsp_valid, o_rsp_data, o_rsp_id, exp_d[k]);
      end
    end
  endtask

  task automatic test_fairness();
    logic exp0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) begin
        req0_valid = 1'b1; req0_data = 32'h0000_1000; req0_amount = 5'd3;  req0_dir = 1'b0;
        req1_valid = 1'b1; req1_data = 32'h0000_2000; req1_amount = 5'd7;  req1_dir = 1'b1;
      end else if ((k - 1) % 2 == 0) begin
        req0_data = 32'h0000_1000 + 32'(k); req0_amount = 5'(k + 9);
      end else begin
        req1_data = 32'h0000_2000 + 32'(k); req1_amount = 5'(k + 17);
      end
      @(negedge clk);
      exp0 = (k % 2 == 0);
      vectors++;
      if (o_req0_ready !== exp0 || o_req1_ready !== !exp0) begin
        miscompares++;
        $display("FAIL fair_grant[%0d]: ready0=%b ready1=%b, expected %b/%b", k, o_req0_ready, o_req1_ready, exp0, !exp0);
      end
      if (k > 0) begin
        vectors++;
        if (o_rsp_valid !== 1'b1 || o_rsp_id !== 1'((k - 1) % 2)) begin
          miscompares++;
          $display("FAIL fair_id[%0d]: valid=%b id=%b, expected 1/%0d", k, o_rsp_valid, o_rsp_id, (k - 1) % 2);
        end
      end
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_id !== 1'b1) begin
      miscompares++;
      $display("FAIL fair_last: valid=%b id=%b, expected 1/1", o_rsp_valid, o_rsp_id);
    end
  endtask

  task automatic test_backpressure();
    step();
    req0_valid = 1'b1; req0_data = 32'hDEAD_BEEF; req0_amount = 5'd8; req0_dir = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    step();
    req0_data = 32'h1234_5678; req0_amount = 5'd4; req0_dir = 1'b1;
    req1_valid = 1'b1; req1_data = 32'hCAFE_F00D; req1_amount = 5'd16; req1_dir = 1'b0;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (o_req0_ready !== 1'b0 || o_req1_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_ready[%0d]: ready0=%b ready1=%b, expected 0/0", k, o_req0_ready, o_req1_ready);
      end
      vectors++;
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'hADBE_EFDE || o_rsp_id !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h id=%b, expected 1/adbeefde/0", k, o_rsp_valid, o_rsp_data, o_rsp_id);
      end
      if (k < 2) step();
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_req1_ready !== 1'b1 || o_req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: ready0=%b ready1=%b, expected 0/1", o_req0_ready, o_req1_ready);
    end
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'hF00D_CAFE || o_rsp_id !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_rsp1: valid=%b data=%h id=%b, expected 1/f00dcafe/1", o_rsp_valid, o_rsp_data, o_rsp_id);
    end
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h8123_4567 || o_rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_rsp0: valid=%b data=%h id=%b, expected 1/81234567/0", o_rsp_valid, o_rsp_data, o_rsp_id);
    end
  endtask

  task automatic test_reset_mid();
    step();
    req1_valid = 1'b1; req1_data = 32'h0F0F_0000; req1_amount = 5'd2; req1_dir = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    step();
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_id !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pending: valid=%b id=%b, expected 1/1", o_rsp_valid, o_rsp_id);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_rsp_data !== 32'h0 || o_rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b data=%h id=%b, expected 0/0/0", o_rsp_valid, o_rsp_data, o_rsp_id);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    req0_valid = 1'b1; req0_data = 32'h0000_00FF; req0_amount = 5'd31; req0_dir = 1'b1;
    req1_valid = 1'b1; req1_data = 32'hFF00_0000; req1_amount = 5'd1;  req1_dir = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0 || o_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_after: ready0=%b ready1=%b valid=%b, expected 1/0/0", o_req0_ready, o_req1_ready, o_rsp_valid);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h0000_01FE || o_rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_first: valid=%b data=%h id=%b, expected 1/000001fe/0", o_rsp_valid, o_rsp_data, o_rsp_id);
    end
  endtask

  task automatic test_random();
    logic acc0, acc1;
    acc0 = 1'b0; acc1 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      step();
      if (!req0_valid || acc0) begin
        req0_valid  = 1'($urandom_range(0, 1));
        req0_data   = $urandom;
        req0_amount = 5'($urandom_range(0, 31));
        req0_dir    = 1'($urandom_range(0, 1));
      end
      if (!req1_valid || acc1) begin
        req1_valid  = 1'($urandom_range(0, 1));
        req1_data   = $urandom;
        req1_amount = 5'($urandom_range(0, 31));
        req1_dir    = 1'($urandom_range(0, 1));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc0 = req0_valid && o_req0_ready;
      acc1 = req1_valid && o_req1_ready;
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    for (int w = 0; w < 5 && sb.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain: %0d responses outstanding, expected 0", sb.size());
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_req0_only();
    test_req1_only();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
